// File: rtl/neuron_mac.sv
// neuron_mac: fixed-point MAC for one neuron.
// Pipelined weight fetch, saturating multiply/accumulate, bias add.
module neuron_mac #(
    parameter int numWeight    = 3,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int fracBits     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [dataWidth-1:0]    myinput,
    input  logic                    myinputValid,
    input  logic [dataWidth-1:0]    bias,
    output logic                    ren,
    output logic [addressWidth-1:0] radd,
    input  logic [dataWidth-1:0]    wout,
    output logic [dataWidth-1:0]    out,
    output logic                    outValid,
    output logic                    satFlag
);

    localparam int PW = 2 * dataWidth;
    localparam int CW = (numWeight > 1) ? $clog2(numWeight) : 1;

    localparam logic [addressWidth-1:0] LASTA = addressWidth'(numWeight - 1);
    localparam logic [CW-1:0]           LASTC = CW'(numWeight - 1);

    localparam logic [dataWidth-1:0] MAXV = {1'b0, {(dataWidth-1){1'b1}}};
    localparam logic [dataWidth-1:0] MINV = {1'b1, {(dataWidth-1){1'b0}}};

    // Returns {overflow, saturated sum}
    function automatic logic [dataWidth:0] sadd(
        input logic [dataWidth-1:0] a,
        input logic [dataWidth-1:0] b
    );
        logic [dataWidth-1:0] s;
        logic                 ovf;
        s   = a + b;
        ovf = (a[dataWidth-1] == b[dataWidth-1]) &&
              (s[dataWidth-1] != a[dataWidth-1]);
        if (ovf)
            return {1'b1, a[dataWidth-1] ? MINV : MAXV};
        return {1'b0, s};
    endfunction

    // Weight address generation
    assign ren = myinputValid & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            radd <= '0;
        end else if (myinputValid) begin
            if (radd == LASTA)
                radd <= '0;
            else
                radd <= radd + addressWidth'(1);
        end
    end

    // Stage 1: align sample with returned weight
    logic signed [dataWidth-1:0] in_d1;
    logic                        v1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_d1 <= '0;
            v1    <= 1'b0;
        end else begin
            in_d1 <= myinput;
            v1    <= myinputValid;
        end
    end

    // Stage 2: multiply, rescale, saturate
    logic signed [dataWidth-1:0] w_s;
    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        shifted;
    logic [PW-dataWidth:0]       hi;
    logic                        psat;
    logic [dataWidth-1:0]        pval;

    assign w_s     = wout;
    assign prod    = in_d1 * w_s;
    assign shifted = prod >>> fracBits;
    assign hi      = shifted[PW-1:dataWidth-1];

    always_comb begin
        psat = 1'b0;
        pval = shifted[dataWidth-1:0];
        if (!((&hi) || !(|hi))) begin
            psat = 1'b1;
            pval = hi[PW-dataWidth] ? MINV : MAXV;
        end
    end

    logic [dataWidth-1:0] p2;
    logic                 v2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p2 <= '0;
            v2 <= 1'b0;
        end else begin
            p2 <= pval;
            v2 <= v1;
        end
    end

    // Stage 3: accumulate, bias add on the last product
    logic [dataWidth-1:0] acc;
    logic [CW-1:0]        mcnt;
    logic                 sticky;
    logic [dataWidth-1:0] sum;
    logic                 ssat;
    logic [dataWidth-1:0] res;
    logic                 osat;
    logic                 last;

    assign {ssat, sum} = sadd(acc, p2);
    assign {osat, res} = sadd(sum, bias);
    assign last        = (mcnt == LASTC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            mcnt     <= '0;
            out      <= '0;
            outValid <= 1'b0;
            satFlag  <= 1'b0;
        end else begin
            outValid <= 1'b0;
            if (v2) begin
                if (last) begin
                    out      <= res;
                    outValid <= 1'b1;
                    satFlag  <= sticky | ssat | osat;
                    acc      <= '0;
                    mcnt     <= '0;
                end else begin
                    acc  <= sum;
                    mcnt <= mcnt + CW'(1);
                end
            end
        end
    end

    // A product saturating on the clear edge belongs to the next vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sticky <= 1'b0;
        else if (v2 && last)
            sticky <= v1 & psat;
        else
            sticky <= sticky | (v1 & psat) | (v2 & ssat);
    end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed vectors for neuron_mac.
// Small weight-memory model feeds wout one cycle after ren.
module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] myinput = '0;
    logic        myinputValid = 1'b0;
    logic [15:0] bias = '0;
    logic        ren;
    logic [9:0]  radd;
    logic [15:0] wout = '0;
    logic [15:0] out;
    logic        outValid;
    logic        satFlag;

    neuron_mac dut (
        .clk(clk),
        .rst(rst),
        .myinput(myinput),
        .myinputValid(myinputValid),
        .bias(bias),
        .ren(ren),
        .radd(radd),
        .wout(wout),
        .out(out),
        .outValid(outValid),
        .satFlag(satFlag)
    );

    always #5 clk = ~clk;

    logic [15:0] wmem [3];

    always @(posedge clk)
        if (ren) wout <= wmem[radd[1:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] q_out [$];
    logic        q_sat [$];
    int          q_cyc [$];
    logic        prev_ov = 1'b0;
    int          wide = 0;

    always @(negedge clk) begin
        if (outValid) begin
            q_out.push_back(out);
            q_sat.push_back(satFlag);
            q_cyc.push_back(cyc);
        end
        if (outValid && prev_ov) wide <= wide + 1;
        prev_ov <= outValid;
    end

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] x, input int a,
                        output int t);
        myinput = x;
        myinputValid = 1'b1;
        #1;
        chk("ren", 32'(ren), 1);
        chk("radd", 32'(radd), 32'(a));
        t = cyc;
        @(posedge clk);
        #1;
        myinputValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_res(input string tag, input logic [15:0] eo,
                              input logic es, input int tl,
                              output int oc);
        int n = 0;
        oc = 0;
        while (q_out.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_present"}, 32'(q_out.size() != 0), 1);
        if (q_out.size() != 0) begin
            oc = q_cyc.pop_front();
            chk({tag, "_out"}, 32'(q_out.pop_front()), 32'(eo));
            chk({tag, "_sat"}, 32'(q_sat.pop_front()), 32'(es));
            chk({tag, "_lat"}, 32'(oc - tl), 3);
        end
    endtask

    task automatic vec(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input int gap,
                       output int t);
        int tt;
        send(a, 0, tt);
        idle(gap);
        send(b, 1, tt);
        idle(gap);
        send(c, 2, t);
    endtask

    task automatic norm_w();
        wmem[0] = 16'h0100;
        wmem[1] = 16'h0200;
        wmem[2] = 16'hFF80;
    endtask

    int t1, t2, c1, c2, tt;

    initial begin
        norm_w();

        // Reset with valid held
        myinputValid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ren", 32'(ren), 0);
        chk("rst_radd", 32'(radd), 0);
        chk("rst_out", 32'(out), 0);
        chk("rst_ov", 32'(outValid), 0);
        chk("rst_sat", 32'(satFlag), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rel_ren", 32'(ren), 1);
        chk("rel_radd", 32'(radd), 0);
        @(posedge clk);
        #1;
        myinputValid = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // Single vector, back-to-back samples
        bias = 16'h0040;
        vec(16'h0100, 16'h0100, 16'h0200, 0, t1);
        #1;
        chk("wrap_radd", 32'(radd), 0);
        expect_res("case2", 16'h0240, 1'b0, t1, c1);

        // Same vector with idle gaps
        idle(2);
        vec(16'h0100, 16'h0100, 16'h0200, 2, t1);
        expect_res("gaps", 16'h0240, 1'b0, t1, c1);

        // Positive saturation
        idle(2);
        wmem[0] = 16'h7FFF;
        wmem[1] = 16'h7FFF;
        wmem[2] = 16'h7FFF;
        bias = 16'h0000;
        vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 0, t1);
        expect_res("satpos", 16'h7FFF, 1'b1, t1, c1);

        // Negative saturation
        idle(2);
        vec(16'h8000, 16'h8000, 16'h8000, 0, t1);
        expect_res("satneg", 16'h8000, 1'b1, t1, c1);

        // Clean vector clears the flag
        idle(2);
        norm_w();
        bias = 16'h0040;
        vec(16'h0100, 16'h0100, 16'h0200, 0, t1);
        expect_res("clean", 16'h0240, 1'b0, t1, c1);

        // Back-to-back vectors: 1*2 + 2*2 + (-0.5)*2 = 5.0
        idle(2);
        vec(16'h0100, 16'h0100, 16'h0200, 0, t1);
        vec(16'h0200, 16'h0200, 16'h0200, 0, t2);
        // Bias is static within a vector; the second one uses 0
        bias = 16'h0000;
        expect_res("b2b_a", 16'h0240, 1'b0, t1, c1);
        expect_res("b2b_b", 16'h0500, 1'b0, t2, c2);
        chk("b2b_gap", 32'(c2 - c1), 3);

        // Reset mid-vector
        idle(3);
        bias = 16'h0040;
        send(16'h0100, 0, tt);
        send(16'h0100, 1, tt);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(5);
        chk("abort_nopulse", 32'(q_out.size()), 0);
        vec(16'h0100, 16'h0100, 16'h0200, 0, t1);
        expect_res("after_rst", 16'h0240, 1'b0, t1, c1);

        idle(4);
        chk("pulse_width", 32'(wide), 0);
        chk("no_extra", 32'(q_out.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
